// File: rtl/avalon_st_source.sv
// avalon_st_source
//   Avalon-ST packet source. A start command captures up to MAX_BEATS words
//   and a byte length. The message is then emitted as one packet framed with
//   sop/eop/empty, and the block honours ready backpressure (ready latency 0).
//   Symbols are ordered first-byte-in-MSBs. The unused low bytes of the eop
//   beat are driven to zero.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous reset, active low
//   start        command strobe; len and msg_in are sampled with it
//   len          packet length in bytes (valid range 1..MAX_BEATS*WIDTH/8)
//   msg_in       message words; word k is beat k
//   busy         high from accepted start until the final handshake
//   done         one-cycle pulse after the final beat is accepted
//   err          one-cycle pulse when a start is rejected for a bad len
//   data/valid/ready/sop/eop/empty   Avalon-ST source side
//   stall_count  cycles with valid && !ready, saturating
//                (present only when AVST_SRC_STALL_CNT_EN is defined)
//
// Optional feature macro: AVST_SRC_STALL_CNT_EN
module avalon_st_source #(
  parameter int WIDTH       = 64,
  parameter int EMPTY_WIDTH = $clog2(WIDTH/8),
  parameter int MAX_BEATS   = 4,
  parameter int LEN_WIDTH   = $clog2(MAX_BEATS*WIDTH/8+1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [LEN_WIDTH-1:0]            len,
  input  logic [MAX_BEATS-1:0][WIDTH-1:0] msg_in,
  output logic                            busy,
  output logic                            done,
  output logic                            err,
  output logic [WIDTH-1:0]                data,
  output logic                            valid,
  input  logic                            ready,
  output logic                            sop,
  output logic                            eop,
  output logic [EMPTY_WIDTH-1:0]          empty
`ifdef AVST_SRC_STALL_CNT_EN
  ,
  output logic [31:0]                     stall_count
`endif
);

  localparam int BPW     = WIDTH / 8;
  localparam int MAX_LEN = MAX_BEATS * BPW;
  localparam int IDX_W   = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam int BEAT_W  = $clog2(MAX_BEATS + 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                          state_reg, state_next;
  logic [MAX_BEATS-1:0][WIDTH-1:0] msg_reg, msg_next;
  logic [IDX_W-1:0]                idx_reg, idx_next;
  logic [BEAT_W-1:0]               beats_reg, beats_next;
  logic [EMPTY_WIDTH-1:0]          last_empty_reg, last_empty_next;

  logic                            valid_next, sop_next, eop_next;
  logic                            busy_next, done_next, err_next;
  logic [EMPTY_WIDTH-1:0]          empty_next;
  logic [WIDTH-1:0]                data_next;

  // Command decode, evaluated against the live len input
  logic [BEAT_W-1:0]               req_beats;
  logic [EMPTY_WIDTH-1:0]          req_empty;
  logic                            len_ok;
  // Lookahead to the beat after the current one
  logic [IDX_W-1:0]                nidx;
  logic                            n_last;

  assign req_beats = BEAT_W'((32'(len) + BPW - 1) / BPW);
  assign req_empty = EMPTY_WIDTH'(32'(req_beats) * BPW - 32'(len));
  assign len_ok    = (len != '0) && (32'(len) <= MAX_LEN);
  assign nidx      = idx_reg + IDX_W'(1);
  assign n_last    = (BEAT_W'(nidx) == beats_reg - BEAT_W'(1));

  // Zero the trailing unused bytes; they sit in the LSBs because the first
  // symbol occupies the MSBs.
  function automatic logic [WIDTH-1:0] mask_tail(input logic [WIDTH-1:0] w,
                                                 input logic [EMPTY_WIDTH-1:0] e);
    return w & ({WIDTH{1'b1}} << (32'(e) * 8));
  endfunction

  always_comb begin
    state_next      = state_reg;
    msg_next        = msg_reg;
    idx_next        = idx_reg;
    beats_next      = beats_reg;
    last_empty_next = last_empty_reg;
    valid_next      = valid;
    sop_next        = sop;
    eop_next        = eop;
    empty_next      = empty;
    data_next       = data;
    busy_next       = busy;
    done_next       = 1'b0;
    err_next        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          if (len_ok) begin
            msg_next        = msg_in;
            beats_next      = req_beats;
            last_empty_next = req_empty;
            idx_next        = '0;
            state_next      = SEND;
            // Beat 0 is presented straight from the command inputs so valid
            // rises on the accepting edge.
            valid_next      = 1'b1;
            busy_next       = 1'b1;
            sop_next        = 1'b1;
            eop_next        = (req_beats == BEAT_W'(1));
            empty_next      = eop_next ? req_empty : '0;
            data_next       = eop_next ? mask_tail(msg_in[0], req_empty) : msg_in[0];
          end else begin
            err_next = 1'b1;
          end
        end
      end
      SEND: begin
        // Outputs simply hold while the sink stalls.
        if (valid && ready) begin
          if (eop) begin
            state_next = IDLE;
            valid_next = 1'b0;
            busy_next  = 1'b0;
            sop_next   = 1'b0;
            eop_next   = 1'b0;
            empty_next = '0;
            data_next  = '0;
            done_next  = 1'b1;
          end else begin
            idx_next   = nidx;
            sop_next   = 1'b0;
            eop_next   = n_last;
            empty_next = n_last ? last_empty_reg : '0;
            data_next  = n_last ? mask_tail(msg_reg[nidx], last_empty_reg) : msg_reg[nidx];
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      msg_reg        <= '0;
      idx_reg        <= '0;
      beats_reg      <= '0;
      last_empty_reg <= '0;
      valid          <= 1'b0;
      sop            <= 1'b0;
      eop            <= 1'b0;
      empty          <= '0;
      data           <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
    end else begin
      state_reg      <= state_next;
      msg_reg        <= msg_next;
      idx_reg        <= idx_next;
      beats_reg      <= beats_next;
      last_empty_reg <= last_empty_next;
      valid          <= valid_next;
      sop            <= sop_next;
      eop            <= eop_next;
      empty          <= empty_next;
      data           <= data_next;
      busy           <= busy_next;
      done           <= done_next;
      err            <= err_next;
    end
  end

`ifdef AVST_SRC_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
    end else if (valid && !ready && (stall_count != '1)) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_avalon_st_source.sv
// tb_avalon_st_source
//   Randomized scoreboard bench for avalon_st_source. Stimulus pushes the
//   expected beats, computed byte by byte from the message and length, into a
//   queue. A monitor pops and compares on every handshake, and it also checks
//   done pulses, hold-under-backpressure and (optionally) stall_count.
module tb_avalon_st_source;

  localparam int WIDTH       = 64;
  localparam int BPW         = WIDTH / 8;
  localparam int MAX_BEATS   = 4;
  localparam int LEN_WIDTH   = 6;
  localparam int EMPTY_WIDTH = 3;

  logic                            clk = 1'b0;
  logic                            rst = 1'b0;
  logic                            start = 1'b0;
  logic [LEN_WIDTH-1:0]            len = '0;
  logic [MAX_BEATS-1:0][WIDTH-1:0] msg_in = '0;
  logic                            ready = 1'b0;
  logic                            busy, done, err, valid, sop, eop;
  logic [WIDTH-1:0]                data;
  logic [EMPTY_WIDTH-1:0]          empty;
`ifdef AVST_SRC_STALL_CNT_EN
  logic [31:0]                     stall_count;
`endif

  avalon_st_source #(
    .WIDTH(WIDTH), .EMPTY_WIDTH(EMPTY_WIDTH),
    .MAX_BEATS(MAX_BEATS), .LEN_WIDTH(LEN_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .msg_in(msg_in),
    .busy(busy), .done(done), .err(err), .data(data), .valid(valid),
    .ready(ready), .sop(sop), .eop(eop), .empty(empty)
`ifdef AVST_SRC_STALL_CNT_EN
    , .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0]       data;
    logic                   sop;
    logic                   eop;
    logic [EMPTY_WIDTH-1:0] empty;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    failures = 0;
  int    pops = 0;
  logic  ready_force = 1'b1;
  logic  ready_val = 1'b1;
  int    ready_pct = 100;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference: byte i of the packet lives in beat i/BPW, byte lane i%BPW
  // counted from the MSB end; bytes at or beyond len are zero.
  task automatic push_expected(input int l, input logic [MAX_BEATS-1:0][WIDTH-1:0] m);
    int nb;
    beat_t e;
    nb = (l + BPW - 1) / BPW;
    for (int k = 0; k < nb; k++) begin
      e.data = m[k];
      for (int b = 0; b < BPW; b++)
        if (k * BPW + b >= l) e.data[WIDTH-1-8*b -: 8] = 8'h00;
      e.sop   = (k == 0);
      e.eop   = (k == nb - 1);
      e.empty = e.eop ? EMPTY_WIDTH'(nb * BPW - l) : '0;
      exp_q.push_back(e);
    end
  endtask

  function automatic logic [MAX_BEATS-1:0][WIDTH-1:0] rand_msg();
    logic [MAX_BEATS-1:0][WIDTH-1:0] m;
    for (int k = 0; k < MAX_BEATS; k++) m[k] = {$urandom, $urandom};
    return m;
  endfunction

  // Ready driver
  initial forever begin
    @(posedge clk);
    #1;
    if (ready_force) ready = ready_val;
    else             ready = ($urandom_range(99) < ready_pct);
  end

  // Monitor / scoreboard
  initial begin
    logic                   exp_done;
    logic                   prev_valid, prev_ready, prev_sop, prev_eop;
    logic [WIDTH-1:0]       prev_data;
    logic [EMPTY_WIDTH-1:0] prev_empty;
    logic [31:0]            stall_model;
    beat_t                  e;
    exp_done = 1'b0; prev_valid = 1'b0; prev_ready = 1'b0; prev_sop = 1'b0;
    prev_eop = 1'b0; prev_data = '0; prev_empty = '0; stall_model = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_done    = 1'b0;
        prev_valid  = 1'b0;
        stall_model = '0;
      end else begin
        check("done", 64'(done), 64'(exp_done));
        if (exp_done) begin
          check("valid_after_eop", 64'(valid), 64'd0);
          check("busy_after_eop", 64'(busy), 64'd0);
        end
        exp_done = 1'b0;
        if (prev_valid && !prev_ready) begin
          check("hold_data", data, prev_data);
          check("hold_ctl", 64'({valid, sop, eop, empty}),
                64'({1'b1, prev_sop, prev_eop, prev_empty}));
        end
        if (valid) check("busy_with_valid", 64'(busy), 64'd1);
`ifdef AVST_SRC_STALL_CNT_EN
        check("stall_count", 64'(stall_count), 64'(stall_model));
`endif
        if (valid && ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat actual=%h required=no_beat t=%0t", data, $time);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", data, e.data);
            check("beat_ctl", 64'({sop, eop, empty}), 64'({e.sop, e.eop, e.empty}));
            $display("beat data=%h sop=%0b eop=%0b empty=%0d", data, sop, eop, empty);
            if (e.eop) exp_done = 1'b1;
            pops++;
          end
        end
        if (valid && !ready && stall_model != '1) stall_model++;
        prev_valid = valid; prev_ready = ready; prev_sop = sop;
        prev_eop = eop; prev_data = data; prev_empty = empty;
      end
    end
  end

  // All stimulus tasks begin and end 1 time unit after a rising edge.
  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || busy || valid) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n >= 300) begin
      failures++;
      $display("FAIL wait_idle actual=pending_%0d required=0 t=%0t", exp_q.size(), $time);
      exp_q.delete();
    end
  endtask

  task automatic send_pkt(input int l, input logic [MAX_BEATS-1:0][WIDTH-1:0] m);
    wait_idle();
    $display("start len=%0d", l);
    push_expected(l, m);
    start  = 1'b1;
    len    = LEN_WIDTH'(l);
    msg_in = m;
    @(posedge clk);
    #1;
    start  = 1'b0;
    len    = LEN_WIDTH'($urandom);
    msg_in = rand_msg();
    check("accept_valid_sop_busy", 64'({valid, sop, busy}), 64'(3'b111));
  endtask

  task automatic bad_start(input int l);
    wait_idle();
    $display("bad start len=%0d", l);
    start = 1'b1;
    len   = LEN_WIDTH'(l);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("err_pulse", 64'({err, valid, busy}), 64'(3'b100));
    @(posedge clk);
    #1;
    check("err_clear", 64'({err, valid}), 64'(2'b00));
  endtask

  initial begin
    logic [MAX_BEATS-1:0][WIDTH-1:0] m;
    int base, n;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctl", 64'({valid, sop, eop, busy, done, err, empty}), 64'd0);
    check("reset_data", data, 64'd0);
`ifdef AVST_SRC_STALL_CNT_EN
    check("reset_stall_count", 64'(stall_count), 64'd0);
`endif
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Backpressure on beat 1 for three cycles
    send_pkt(32, rand_msg());
    @(posedge clk);
    ready_val = 1'b0;
    repeat (3) @(posedge clk);
    ready_val = 1'b1;
    #1;
    wait_idle();
`ifdef AVST_SRC_STALL_CNT_EN
    check("stall_count_3", 64'(stall_count), 64'd3);
`endif

    // Four beats at full throughput
    m[0] = 64'hA0A0_0000_0000_00A0; m[1] = 64'hA1A1_1111_1111_11A1;
    m[2] = 64'hA2A2_2222_2222_22A2; m[3] = 64'hA3A3_3333_3333_33A3;
    send_pkt(32, m);
    base = pops;
    repeat (4) @(posedge clk);
    #1;
    check("throughput", 64'(pops - base), 64'd4);

    send_pkt(13, rand_msg());
    send_pkt(5, rand_msg());
    bad_start(0);
    bad_start(33);

    // Start during SEND is ignored
    wait_idle();
    ready_val = 1'b0;
    send_pkt(27, rand_msg());
    start = 1'b1;
    len   = LEN_WIDTH'(5);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("ignored_start", 64'({err, busy, valid, sop}), 64'(4'b0111));
    ready_val = 1'b1;
    wait_idle();

    // Randomized traffic
    ready_force = 1'b0;
    for (int i = 0; i < 40; i++) begin
      ready_pct = $urandom_range(30, 100);
      if ($urandom_range(7) == 0)
        bad_start(($urandom_range(1) == 0) ? 0 : int'($urandom_range(33, 63)));
      else
        send_pkt(int'($urandom_range(1, 32)), rand_msg());
    end
    wait_idle();
    ready_force = 1'b1;
    ready_val   = 1'b1;
    @(posedge clk);
    #1;

    // Reset while beat 2 of a 4-beat packet is presented
    send_pkt(32, rand_msg());
    base = pops;
    n = 0;
    while (pops < base + 2 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #2;
    check("pre_reset_mid_packet", 64'({valid, sop}), 64'(2'b10));
    rst = 1'b0;
    #1;
    check("async_reset_ctl", 64'({valid, sop, eop, busy, done, err, empty}), 64'd0);
    check("async_reset_data", data, 64'd0);
    exp_q.delete();
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("idle_after_reset", 64'({valid, busy}), 64'd0);
    send_pkt(8, rand_msg());
    wait_idle();
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/avalon_st_source.md
# avalon_st_source

Avalon-ST packet source that sits directly upstream of the `avalon_st_sink` stage. On a start command it captures a message of up to MAX_BEATS words and a byte length. It then emits the message as one Avalon-ST packet, framed with sop/eop/empty, and honours ready backpressure from the sink. It is the stimulus and egress stage for the streaming path in the test environments.

## Interface
- WIDTH, 64, data bus width in bits (multiple of 8)
- EMPTY_WIDTH, $clog2(WIDTH/8), width of empty
- MAX_BEATS, 4, maximum beats per packet
- LEN_WIDTH, $clog2(MAX_BEATS*WIDTH/8+1), width of byte-length input
- clk  input  1  clock; all logic on rising edge
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- start  input  1  command strobe, sampled each cycle
- len  input  LEN_WIDTH  packet length in bytes, sampled with start
- msg_in  input  [MAX_BEATS-1:0][WIDTH-1:0]  message words, sampled with start; word k is beat k
- busy  output  1  high from accepted start until final handshake
- done  output  1  one-cycle pulse after final beat accepted
- err  output  1  one-cycle pulse when start is rejected
- data  output  WIDTH  beat payload
- valid  output  1  beat valid
- ready  input  1  sink ready, ready latency 0
- sop  output  1  first beat of packet
- eop  output  1  last beat of packet
- empty  output  EMPTY_WIDTH  unused bytes in the eop beat; 0 on other beats
- stall_count  output  32  stall counter; present only with AVST_SRC_STALL_CNT_EN

## Operation
- FSM states: IDLE, SEND.
- IDLE, start=1, 1 ≤ len ≤ MAX_BEATS*WIDTH/8:
  - capture msg_in and len
  - beats = ceil(len/(WIDTH/8))
  - beat index ← 0
  - go to SEND
- IDLE, start=1 with len=0 or len above the limit: stay in IDLE, pulse err next cycle, capture nothing.
- start while in SEND is ignored. No err is raised.
- SEND:
  - valid=1, data=captured word[index], sop=(index==0), eop=(index==beats-1).
  - A handshake is valid&&ready on a rising edge. On each handshake the index increments.
  - The handshake on the eop beat returns the FSM to IDLE.
- eop beat:
  - empty = beats*(WIDTH/8) − len.
  - Symbol order is first-byte-in-MSBs, so the low empty*8 bits of data are forced to 0.
- A single-beat packet asserts sop and eop together.
- Index width is $clog2(MAX_BEATS) bits. It never wraps, because exit occurs at beats-1.

## Timing
- All outputs are registered.
- Reset value of every output is 0: valid, sop, eop, empty, data, busy, done, err, stall_count. FSM resets to IDLE.
- start accepted at edge T gives valid=1, sop=1, busy=1 from T onward. Latency is 1 cycle.
- While valid && !ready, data, sop, eop and empty hold unchanged.
- After a handshake, the next beat is presented in the following cycle, so full throughput is 1 beat/clock when ready stays high.
- Final handshake at edge E: after E, valid=0, busy=0 and done=1 for one cycle.
- A start sampled during the done cycle is accepted, so there is at least one idle cycle between packets.
- Reset asserted mid-packet forces all outputs to 0 asynchronously and abandons the packet. After deassertion the block waits in IDLE for a new start.

## Configuration
- AVST_SRC_STALL_CNT_EN defined:
  - stall_count increments (saturating at 2^32−1) every cycle with valid && !ready.
  - Cleared only by reset.
- AVST_SRC_STALL_CNT_EN undefined:
  - port and counter absent.
  - all other behaviour identical.

## Test plan
- start, len=32, msg_in={A3,A2,A1,A0}, ready=1 -> 4 consecutive beats A0..A3; sop on A0; eop on A3; empty=0; done one cycle after the A3 handshake.
- start, len=13, ready=1 -> 2 beats; beat 1 has eop=1, empty=3, low 24 bits of data=0.
- start, len=5 -> single beat with sop=eop=1, empty=3.
- len=32, ready low for 3 cycles while beat 1 is presented -> beat 1 fields held stable. With the macro defined, stall_count=3 at the end.
- len=0, then len=33 -> err pulses each time; valid never asserts. start during SEND -> ignored, packet unchanged.
- rst=0 during beat 2 of a 4-beat packet -> all outputs 0 immediately. After release, a new len=8 packet emits 1 beat normally.
